// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse player: FSM states, default divider
// and the S..Z symbol patterns (1 = LED on, MSB plays first).
package morse_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    // 50 MHz clock, 2 Hz unit rate.
    localparam int DEFAULT_TICK_DIV = 25000000;

    localparam logic [15:0] MORSE_S_TO_Z [0:7] = '{
        16'hA800,  // S  ...
        16'hE000,  // T  -
        16'hAE00,  // U  ..-
        16'hAB80,  // V  ...-
        16'hBB80,  // W  .--
        16'hEAE0,  // X  -..-
        16'hEBB8,  // Y  -.--
        16'hEEA0   // Z  --..
    };

endpackage

// File: rtl/morse_tick_gen.sv
// Loadable down-counter producing a one-cycle tick every TICK_DIV enabled cycles.
// clear restarts the count at TICK_DIV-1; the counter reloads itself on each tick.
module morse_tick_gen
    import morse_pkg::*;
#(
    parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic en,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values, independent of block ordering.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            count <= '0;
        else if (clear || tick)
            count <= RELOAD;
        else if (en)
            count <= count - 1'b1;
    end

    assign tick = en && (count == '0);

endmodule

// File: rtl/morse_player.sv
// Parametrised Morse pattern player: start/busy/done handshake with stop, MSB-first
// onto led. Define MORSE_REPEAT_EN to enable looping with a GAP_UNITS silent gap.
module morse_player
    import morse_pkg::*;
#(
    parameter int PAT_W     = 16,
    parameter int TICK_DIV  = DEFAULT_TICK_DIV,
    parameter int GAP_UNITS = 7,
    parameter int LEN_W     = $clog2(PAT_W + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             stop,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic             repeat_en,
    output logic             led,
    output logic             busy,
    output logic             done
);

    localparam int GAP_W = $clog2(GAP_UNITS + 1);
    localparam int CNT_W = (LEN_W > GAP_W) ? LEN_W : GAP_W;

    state_t           state, next_state;
    logic [PAT_W-1:0] shreg;
    logic [CNT_W-1:0] unit_cnt;
    logic [LEN_W-1:0] len_clamped;
    logic             tick, accept, last_unit, done_d;

`ifdef MORSE_REPEAT_EN
    logic [PAT_W-1:0] pat_q;
    logic [CNT_W-1:0] len_q;
`else
    logic unused_repeat_en;
    assign unused_repeat_en = repeat_en;
`endif

    assign len_clamped = (len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : len;
    assign accept      = (state == IDLE) && start && !stop;
    assign last_unit   = tick && (unit_cnt == CNT_W'(1));

    morse_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (accept),
        .en      (state != IDLE),
        .tick    (tick)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    // NOTE: every combinational output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        done_d     = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (len_clamped != '0)
                        next_state = PLAY;
                    else
                        done_d = 1'b1;
                end
            end
            PLAY: begin
                if (stop) begin
                    next_state = IDLE;
                end else if (last_unit) begin
                    done_d = 1'b1;
`ifdef MORSE_REPEAT_EN
                    next_state = repeat_en ? GAP : IDLE;
`else
                    next_state = IDLE;
`endif
                end
            end
`ifdef MORSE_REPEAT_EN
            GAP: begin
                if (stop)
                    next_state = IDLE;
                else if (last_unit)
                    next_state = PLAY;
            end
`endif
            default: next_state = IDLE;
        endcase
    end

    // unit_cnt counts remaining pattern units in PLAY and remaining silent units in GAP.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shreg    <= '0;
            unit_cnt <= '0;
            done     <= 1'b0;
        end else begin
            done <= done_d;
            if (accept) begin
                shreg    <= pattern;
                unit_cnt <= CNT_W'(len_clamped);
`ifdef MORSE_REPEAT_EN
            end else if (state == PLAY && next_state == GAP) begin
                unit_cnt <= CNT_W'(GAP_UNITS);
            end else if (state == GAP && next_state == PLAY) begin
                shreg    <= pat_q;
                unit_cnt <= len_q;
`endif
            end else if (tick) begin
                shreg    <= shreg << 1;
                unit_cnt <= unit_cnt - 1'b1;
            end
        end
    end

`ifdef MORSE_REPEAT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pat_q <= '0;
            len_q <= '0;
        end else if (accept) begin
            pat_q <= pattern;
            len_q <= CNT_W'(len_clamped);
        end
    end
`endif

    assign led  = (state == PLAY) && shreg[PAT_W-1];
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_morse_player.sv
// Directed self-checking bench for morse_player (TICK_DIV=4, PAT_W=16, GAP_UNITS=2).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_morse_player;

    localparam int PAT_W     = 16;
    localparam int TICK_DIV  = 4;
    localparam int GAP_UNITS = 2;
    localparam int LEN_W     = 5;

    logic             clock;
    logic             reset_n;
    logic             start;
    logic             stop;
    logic [PAT_W-1:0] pattern;
    logic [LEN_W-1:0] len;
    logic             repeat_en;
    logic             led;
    logic             busy;
    logic             done;

    int total = 0;
    int bad   = 0;

    morse_player #(
        .PAT_W     (PAT_W),
        .TICK_DIV  (TICK_DIV),
        .GAP_UNITS (GAP_UNITS),
        .LEN_W     (LEN_W)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .stop      (stop),
        .pattern   (pattern),
        .len       (len),
        .repeat_en (repeat_en),
        .led       (led),
        .busy      (busy),
        .done      (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Returns at the falling edge right after the accepting rising edge (j = 0).
    task automatic kick(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] l);
        pattern = p;
        len     = l;
        start   = 1'b1;
        @(negedge clock);
        start   = 1'b0;
    endtask

    task automatic test_reset();
        logic [2:0] exp;
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        total++;
        if ({led, busy, done} !== 3'b000) begin
            bad++;
            $display("FAIL reset_idle {led,busy,done}=%b expected 000", {led, busy, done});
        end
        reset_n = 1'b1;
        @(negedge clock);
        kick(16'hFFFF, 5'd16);
        repeat (5) @(negedge clock);
        exp = 3'b110;
        total++;
        if ({led, busy, done} !== exp) begin
            bad++;
            $display("FAIL reset_preplay {led,busy,done}=%b expected %b", {led, busy, done}, exp);
        end
        reset_n = 1'b0;
        #1;
        total++;
        if ({led, busy, done} !== 3'b000) begin
            bad++;
            $display("FAIL reset_async {led,busy,done}=%b expected 000", {led, busy, done});
        end
        @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        total++;
        if ({led, busy, done} !== 3'b000) begin
            bad++;
            $display("FAIL reset_release {led,busy,done}=%b expected 000", {led, busy, done});
        end
    endtask

    task automatic test_pattern_s();
        logic [PAT_W-1:0] p;
        logic [2:0]       exp;
        p = 16'hA800;
        kick(p, 5'd5);
        for (int j = 0; j <= 21; j++) begin
            if (j < 20)       exp = {p[15 - j/4], 2'b10};
            else if (j == 20) exp = 3'b001;
            else              exp = 3'b000;
            total++;
            if ({led, busy, done} !== exp) begin
                bad++;
                $display("FAIL pattern_s j=%0d {led,busy,done}=%b expected %b", j, {led, busy, done}, exp);
            end
            @(negedge clock);
        end
    endtask

    task automatic test_len_zero();
        kick(16'hFFFF, 5'd0);
        total++;
        if ({led, busy, done} !== 3'b001) begin
            bad++;
            $display("FAIL len_zero_pulse {led,busy,done}=%b expected 001", {led, busy, done});
        end
        for (int j = 1; j <= 3; j++) begin
            @(negedge clock);
            total++;
            if ({led, busy, done} !== 3'b000) begin
                bad++;
                $display("FAIL len_zero_after j=%0d {led,busy,done}=%b expected 000", j, {led, busy, done});
            end
        end
    endtask

    task automatic test_clamp_ignore_start();
        logic [PAT_W-1:0] p;
        logic [2:0]       exp;
        p = 16'hA5F1;
        kick(p, 5'd20);
        for (int j = 0; j <= 65; j++) begin
            if (j < 64)       exp = {p[15 - j/4], 2'b10};
            else if (j == 64) exp = 3'b001;
            else              exp = 3'b000;
            total++;
            if ({led, busy, done} !== exp) begin
                bad++;
                $display("FAIL clamp j=%0d {led,busy,done}=%b expected %b", j, {led, busy, done}, exp);
            end
            if (j == 10) begin
                start   = 1'b1;
                pattern = 16'h0F0F;
                len     = 5'd3;
            end else begin
                start   = 1'b0;
            end
            @(negedge clock);
        end
    endtask

    task automatic test_stop();
        logic [2:0] exp;
        kick(16'hFFFF, 5'd16);
        repeat (9) @(negedge clock);
        stop = 1'b1;
        @(negedge clock);
        stop = 1'b0;
        for (int j = 0; j < 6; j++) begin
            total++;
            if ({led, busy, done} !== 3'b000) begin
                bad++;
                $display("FAIL stop_abort j=%0d {led,busy,done}=%b expected 000", j, {led, busy, done});
            end
            @(negedge clock);
        end
        kick(16'hC000, 5'd2);
        for (int j = 0; j <= 8; j++) begin
            exp = (j < 8) ? 3'b110 : 3'b001;
            total++;
            if ({led, busy, done} !== exp) begin
                bad++;
                $display("FAIL stop_restart j=%0d {led,busy,done}=%b expected %b", j, {led, busy, done}, exp);
            end
            @(negedge clock);
        end
    endtask

`ifdef MORSE_REPEAT_EN
    task automatic test_repeat();
        logic [2:0] exp;
        repeat_en = 1'b1;
        kick(16'hE000, 5'd3);
        for (int j = 0; j <= 53; j++) begin
            if (j < 52)       exp = {((j % 20) < 12), 1'b1, ((j % 20) == 12)};
            else if (j == 52) exp = 3'b001;
            else              exp = 3'b000;
            total++;
            if ({led, busy, done} !== exp) begin
                bad++;
                $display("FAIL repeat j=%0d {led,busy,done}=%b expected %b", j, {led, busy, done}, exp);
            end
            if (j == 45) repeat_en = 1'b0;
            @(negedge clock);
        end
    endtask
`else
    task automatic test_repeat();
        logic [2:0] exp;
        repeat_en = 1'b1;
        kick(16'hE000, 5'd3);
        for (int j = 0; j <= 20; j++) begin
            if (j < 12)       exp = 3'b110;
            else if (j == 12) exp = 3'b001;
            else              exp = 3'b000;
            total++;
            if ({led, busy, done} !== exp) begin
                bad++;
                $display("FAIL repeat_ignored j=%0d {led,busy,done}=%b expected %b", j, {led, busy, done}, exp);
            end
            @(negedge clock);
        end
        repeat_en = 1'b0;
    endtask
`endif

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        pattern   = '0;
        len       = '0;
        repeat_en = 1'b0;
        test_reset();
        test_pattern_s();
        test_len_zero();
        test_clamp_ignore_start();
        test_stop();
        test_repeat();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
